// File: rtl/nrs_index_seq_if.sv
// Index stream from the NRS index sequencer to the demapper/estimator.
// The producer holds index and tags stable while out_valid is high and out_ready is low.
interface nrs_index_seq_if;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] index_demap;
  logic       sym_sel;
  logic       port_sel;
  logic       slot_sel;

  modport master (
    output out_valid, index_demap, sym_sel, port_sel, slot_sel,
    input  out_ready
  );

  modport slave (
    input  out_valid, index_demap, sym_sel, port_sel, slot_sel,
    output out_ready
  );
endinterface

// File: rtl/nrs_index_seq.sv
// NRS pilot subcarrier index sequencer: derives v_shift = cell ID mod 6 serially,
// then streams (slot, port, sym, k) pilot rows with a valid/ready handshake.
module nrs_index_seq #(
  parameter int N_PORTS = 1,
  parameter int N_SLOTS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [8:0]         N_cell_ID,
  output logic [2:0]         v_shift,
  output logic               busy,
  output logic               done,
  output logic               id_err,
  nrs_index_seq_if.master    stream
);
  localparam int N_BEATS = 4 * N_PORTS * N_SLOTS;

  typedef enum logic [1:0] {IDLE, MOD, GEN, DONE} state_t;

  state_t      state_reg, state_next;
  logic [9:0]  rem_reg;
  logic [2:0]  stage_reg;
  logic [4:0]  beat_reg;

  // Divisor for each restoring stage: 6 << stage (entry 7 is never selected).
  logic [9:0]  div_tbl [0:7];
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_div
      assign div_tbl[gi] = 10'(6 << gi);
    end
  endgenerate

  logic [9:0]  div_cur;
  logic [9:0]  rem_sub;
  assign div_cur = div_tbl[stage_reg];
  assign rem_sub = (rem_reg >= div_cur) ? (rem_reg - div_cur) : rem_reg;

  // Beat counter bit fields, innermost first: k, sym, port, slot.
  logic beat_k, beat_sym, beat_port, beat_slot;
  assign beat_k    = beat_reg[0];
  assign beat_sym  = beat_reg[1];
  assign beat_port = (N_PORTS == 2) ? beat_reg[2] : 1'b0;
  assign beat_slot = (N_SLOTS == 2) ? ((N_PORTS == 2) ? beat_reg[3] : beat_reg[2]) : 1'b0;

  logic [4:0] tri_sum, idx_sum, idx_r1, idx_r2;
  assign tri_sum = 5'(beat_sym) + 5'(beat_port);
  assign idx_sum = 5'(v_shift) + tri_sum + (tri_sum << 1) + (beat_k ? 5'd6 : 5'd0);
  assign idx_r1  = (idx_sum >= 5'd12) ? (idx_sum - 5'd12) : idx_sum;
  assign idx_r2  = (idx_r1  >= 5'd12) ? (idx_r1  - 5'd12) : idx_r1;

  logic fire, last_fire, load;
  assign fire      = stream.out_valid & stream.out_ready;
  assign last_fire = fire && (beat_reg == 5'(N_BEATS));
  assign load      = (state_reg == GEN) && (!stream.out_valid || fire) &&
                     (beat_reg != 5'(N_BEATS));

  assign busy = (state_reg != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = MOD;
      MOD:     if (stage_reg == 3'd0) state_next = GEN;
      GEN:     if (last_fire) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_reg            <= '0;
      stage_reg          <= '0;
      beat_reg           <= '0;
      v_shift            <= '0;
      id_err             <= 1'b0;
      done               <= 1'b0;
      stream.out_valid   <= 1'b0;
      stream.index_demap <= '0;
      stream.sym_sel     <= 1'b0;
      stream.port_sel    <= 1'b0;
      stream.slot_sel    <= 1'b0;
    end else begin
      done <= (state_reg == GEN) && last_fire;
      case (state_reg)
        IDLE: begin
          if (start) begin
            rem_reg   <= {1'b0, N_cell_ID};
            stage_reg <= 3'd6;
            beat_reg  <= '0;
            id_err    <= (N_cell_ID > 9'd503);
          end
        end
        MOD: begin
          rem_reg   <= rem_sub;
          stage_reg <= stage_reg - 3'd1;
          if (stage_reg == 3'd0) v_shift <= rem_sub[2:0];
        end
        GEN: begin
          if (load) begin
            stream.out_valid   <= 1'b1;
            stream.index_demap <= idx_r2[3:0];
            stream.sym_sel     <= beat_sym;
            stream.port_sel    <= beat_port;
            stream.slot_sel    <= beat_slot;
            beat_reg           <= beat_reg + 5'd1;
          end else if (last_fire) begin
            stream.out_valid   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_nrs_index_seq.sv
// Directed bench for nrs_index_seq: a 1-port/1-slot and a 2-port/2-slot instance,
// expected beats queued by the stimulus and checked by a negedge monitor.
module tb_nrs_index_seq;
  logic       clk = 0;
  logic       rst = 1;
  logic       start_a = 0, start_b = 0;
  logic [8:0] id_a = 0, id_b = 0;
  logic [2:0] vs_a, vs_b;
  logic       busy_a, busy_b, done_a, done_b, err_a, err_b;

  nrs_index_seq_if ifa ();
  nrs_index_seq_if ifb ();

  always #5 clk = ~clk;

  nrs_index_seq #(.N_PORTS(1), .N_SLOTS(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .N_cell_ID(id_a),
    .v_shift(vs_a), .busy(busy_a), .done(done_a), .id_err(err_a), .stream(ifa)
  );

  nrs_index_seq #(.N_PORTS(2), .N_SLOTS(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .N_cell_ID(id_b),
    .v_shift(vs_b), .busy(busy_b), .done(done_b), .id_err(err_b), .stream(ifb)
  );

  int total = 0;
  int bad = 0;
  int xfer_a = 0, xfer_b = 0;
  logic [6:0] exp_a[$];
  logic [6:0] exp_b[$];
  string cn_q[$];
  int    ca_q[$];
  int    ce_q[$];

  function automatic logic [6:0] pk(input int slot, input int port, input int sym, input int idx);
    return {slot[0], port[0], sym[0], idx[3:0]};
  endfunction

  // Single checking process: drains direct checks from the stimulus, then scoreboards beats.
  logic [6:0] cur_a, cur_b, hold_a, e7;
  logic       hold_a_v = 0;
  string      cn;
  int         ca, ce;
  always @(negedge clk) begin
    while (cn_q.size() > 0) begin
      cn = cn_q.pop_front();
      ca = ca_q.pop_front();
      ce = ce_q.pop_front();
      total++;
      if (ca != ce) begin
        bad++;
        $display("FAIL %s: got %0d expected %0d", cn, ca, ce);
      end
    end
    cur_a = {ifa.slot_sel, ifa.port_sel, ifa.sym_sel, ifa.index_demap};
    cur_b = {ifb.slot_sel, ifb.port_sel, ifb.sym_sel, ifb.index_demap};
    if (hold_a_v && ifa.out_valid) begin
      total++;
      if (cur_a !== hold_a) begin
        bad++;
        $display("FAIL hold_a: got %h expected %h", cur_a, hold_a);
      end
    end
    hold_a_v = ifa.out_valid && !ifa.out_ready && !rst;
    hold_a   = cur_a;
    if (!rst && ifa.out_valid && ifa.out_ready) begin
      total++;
      xfer_a++;
      if (exp_a.size() == 0) begin
        bad++;
        $display("FAIL beat_a: got %h expected none", cur_a);
      end else begin
        e7 = exp_a.pop_front();
        if (cur_a !== e7) begin
          bad++;
          $display("FAIL beat_a: got %h expected %h", cur_a, e7);
        end else
          $display("beat a: slot=%0d port=%0d sym=%0d idx=%0d", cur_a[6], cur_a[5], cur_a[4], cur_a[3:0]);
      end
    end
    if (!rst && ifb.out_valid && ifb.out_ready) begin
      total++;
      xfer_b++;
      if (exp_b.size() == 0) begin
        bad++;
        $display("FAIL beat_b: got %h expected none", cur_b);
      end else begin
        e7 = exp_b.pop_front();
        if (cur_b !== e7) begin
          bad++;
          $display("FAIL beat_b: got %h expected %h", cur_b, e7);
        end else
          $display("beat b: slot=%0d port=%0d sym=%0d idx=%0d", cur_b[6], cur_b[5], cur_b[4], cur_b[3:0]);
      end
    end
  end

  task automatic chk(input string n, input int a, input int e);
    cn_q.push_back(n);
    ca_q.push_back(a);
    ce_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input int i0, input int i1, input int i2, input int i3);
    exp_a.push_back(pk(0, 0, 0, i0));
    exp_a.push_back(pk(0, 0, 0, i1));
    exp_a.push_back(pk(0, 0, 1, i2));
    exp_a.push_back(pk(0, 0, 1, i3));
  endtask

  task automatic start_run(input bit sel, input logic [8:0] id);
    if (sel) begin start_b = 1; id_b = id; end
    else     begin start_a = 1; id_a = id; end
    step();
    start_a = 0;
    start_b = 0;
  endtask

  task automatic wait_valid_a(input string n);
    int k = 0;
    while (!ifa.out_valid && k < 50) begin step(); k++; end
    if (!ifa.out_valid) chk({n, "_valid_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input bit sel, input int base, input int beats, input string n);
    int k = 0;
    while (!(sel ? done_b : done_a) && k < 200) begin step(); k++; end
    if (!(sel ? done_b : done_a)) chk({n, "_done_timeout"}, 0, 1);
    else begin
      chk({n, "_xfers"}, (sel ? xfer_b : xfer_a) - base, beats);
      chk({n, "_valid_at_done"}, int'(sel ? ifb.out_valid : ifa.out_valid), 0);
      chk({n, "_queue_left"}, sel ? exp_b.size() : exp_a.size(), 0);
      step();
      chk({n, "_done_width"}, int'(sel ? done_b : done_a), 0);
      chk({n, "_busy_after"}, int'(sel ? busy_b : busy_a), 0);
    end
  endtask

  int p0[4] = '{1, 7, 4, 10};
  int p1[4] = '{4, 10, 7, 1};
  int base;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.out_ready = 1;
    ifb.out_ready = 1;
    repeat (3) step();
    chk("rst_valid_a", int'(ifa.out_valid), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_vs_b", int'(vs_b), 0);
    chk("rst_done_b", int'(done_b), 0);
    rst = 0;
    step();

    // ID 0: sequence 0,6,3,9 and first valid 8 edges after the start edge
    push_a(0, 6, 3, 9);
    base = xfer_a;
    start_run(0, 9'd0);
    repeat (7) step();
    chk("lat_valid_t7", int'(ifa.out_valid), 0);
    step();
    chk("lat_valid_t8", int'(ifa.out_valid), 1);
    chk("id0_vshift", int'(vs_a), 0);
    chk("id0_busy", int'(busy_a), 1);
    wait_done(0, base, 4, "id0");

    // ID 503 and 509 both give v_shift 5; only 509 flags id_err
    push_a(5, 11, 8, 2);
    base = xfer_a;
    start_run(0, 9'd503);
    wait_done(0, base, 4, "id503");
    chk("id503_vshift", int'(vs_a), 5);
    chk("id503_err", int'(err_a), 0);
    push_a(5, 11, 8, 2);
    base = xfer_a;
    start_run(0, 9'd509);
    wait_done(0, base, 4, "id509");
    chk("id509_vshift", int'(vs_a), 5);
    chk("id509_err", int'(err_a), 1);

    // Two ports, two slots, ID 7
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 4; i++) exp_b.push_back(pk(s, 0, i / 2, p0[i]));
    for (int s = 0; s < 2; s++) ;
    exp_b.delete();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) exp_b.push_back(pk(s, 0, i / 2, p0[i]));
      for (int i = 0; i < 4; i++) exp_b.push_back(pk(s, 1, i / 2, p1[i]));
    end
    base = xfer_b;
    start_run(1, 9'd7);
    wait_done(1, base, 16, "id7b");
    chk("id7b_vshift", int'(vs_b), 1);

    // Backpressure on the second beat for three cycles
    push_a(0, 6, 3, 9);
    base = xfer_a;
    start_run(0, 9'd0);
    wait_valid_a("bp");
    step();
    ifa.out_ready = 0;
    step();
    chk("bp_hold_idx", int'(ifa.index_demap), 6);
    chk("bp_hold_valid", int'(ifa.out_valid), 1);
    step();
    step();
    ifa.out_ready = 1;
    wait_done(0, base, 4, "bp");

    // Asynchronous reset after two transferred beats, then a fresh run with ID 13
    push_a(0, 6, 3, 9);
    base = xfer_a;
    start_run(0, 9'd0);
    begin
      int k = 0;
      while (xfer_a - base < 2 && k < 50) begin step(); k++; end
      if (xfer_a - base < 2) chk("rst_mid_timeout", 0, 1);
    end
    #2 rst = 1;
    #1;
    chk("arst_valid", int'(ifa.out_valid), 0);
    chk("arst_index", int'(ifa.index_demap), 0);
    chk("arst_tags", int'({ifa.sym_sel, ifa.port_sel, ifa.slot_sel}), 0);
    chk("arst_vshift", int'(vs_a), 0);
    chk("arst_busy", int'(busy_a), 0);
    exp_a.delete();
    step();
    rst = 0;
    step();
    push_a(1, 7, 4, 10);
    base = xfer_a;
    start_run(0, 9'd13);
    wait_done(0, base, 4, "id13");
    chk("id13_vshift", int'(vs_a), 1);

    // Starts with another ID while busy are ignored
    push_a(1, 7, 4, 10);
    base = xfer_a;
    start_run(0, 9'd7);
    step();
    step();
    start_run(0, 9'd20);
    wait_valid_a("busy_start");
    start_run(0, 9'd20);
    wait_done(0, base, 4, "busy_start");
    chk("busy_start_vshift", int'(vs_a), 1);

    step();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nrs_index_seq.md
NRS_INDEX_SEQ -- requirements
Module: nrs_index_seq

Interface
REQ-001 Parameter N_PORTS, default 1, number of NRS antenna ports (legal values 1 or 2).
REQ-002 Parameter N_SLOTS, default 2, number of slots sequenced per run (legal values 1 or 2).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin a run; sampled only in IDLE.
REQ-006 N_cell_ID  input  9  physical cell ID; captured on an accepted start.
REQ-007 out_ready  input  1  consumer (demapper/estimator) accepts the current index.
REQ-008 out_valid  output  1  index_demap and its tags are valid.
REQ-009 index_demap  output  4  subcarrier row 0..11 of the current pilot.
REQ-010 sym_sel  output  1  symbol tag: 0 = first NRS symbol of slot, 1 = second.
REQ-011 port_sel  output  1  antenna port tag: 0 = port 2000, 1 = port 2001.
REQ-012 slot_sel  output  1  slot tag.
REQ-013 v_shift  output  3  registered N_cell_ID mod 6; held after a run.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse at end of run.
REQ-016 id_err  output  1  registered flag: captured N_cell_ID > 503.

Function
REQ-017 FSM states: IDLE, MOD, GEN, DONE.
REQ-018 IDLE -> MOD on start=1; N_cell_ID latched; id_err updated; start in any other state is ignored.
REQ-019 MOD: restoring subtraction over 7 cycles, stage k = 6..0 compares remainder with 6<<k (384,192,96,48,24,12,6) and subtracts if >=; 10-bit remainder; result written to v_shift on the 7th cycle; MOD -> GEN.
REQ-020 Fixed latency: with start sampled at edge t, out_valid first rises after edge t+8.
REQ-021 GEN emits 4*N_PORTS*N_SLOTS beats in nested order: slot (outer), port, sym, k (inner), k in {0,1}.
REQ-022 index_demap = (v_shift + 3*(sym_sel + port_sel) + 6*k) mod 12; computed with 5-bit intermediate, reduced by conditional subtractions of 12; never outside 0..11.
REQ-023 Handshake: a beat transfers on a clock edge where out_valid=1 and out_ready=1; while out_valid=1 and out_ready=0, index_demap, sym_sel, port_sel and slot_sel hold stable; out_valid does not drop before transfer.
REQ-024 Back-to-back transfers at one beat per cycle when out_ready is held high; no bubbles inside GEN.
REQ-025 After the last transfer: GEN -> DONE; out_valid=0 next cycle; done=1 for exactly that one cycle; DONE -> IDLE.
REQ-026 Index sequence identical in both slots; slot_sel is the only difference.
REQ-027 id_err does not alter sequencing; indices for IDs 504..511 follow the same mod-6 rule.
REQ-028 N_PORTS=1: port_sel is constant 0.
REQ-029 Outputs registered; no combinational path from out_ready to out_valid.

Reset
REQ-030 rst=1 forces IDLE immediately, at any state including mid-MOD or mid-GEN with a pending beat. out_valid, index_demap, sym_sel, port_sel, slot_sel, v_shift, busy, done and id_err all go to 0. Beat counter and remainder are cleared.
REQ-031 After rst deasserts, the first start is accepted normally. No partial run resumes.

Verification
REQ-032 N_PORTS=1, N_SLOTS=1, ID=0, out_ready=1 -> v_shift=0; beats 0,6,3,9; done 1 cycle after the 4th beat; first valid 8 cycles after start.
REQ-033 N_PORTS=1, N_SLOTS=1, ID=503 -> v_shift=5; beats 5,11,8,2; id_err=0. Repeat with ID=509 -> v_shift=5, id_err=1.
REQ-034 N_PORTS=2, N_SLOTS=2, ID=7 -> v_shift=1; per slot: port0 1,7,4,10 and port1 4,10,7,1; 16 beats; slot_sel flips after beat 8.
REQ-035 Backpressure on the 2nd beat: out_ready low for 3 cycles -> index_demap and tags held; no beat lost or duplicated; total beat count unchanged.
REQ-036 rst pulsed during GEN after 2 beats -> all outputs 0 asynchronously; next start with ID=13 -> v_shift=1, full sequence from beat 0.
REQ-037 start asserted while busy with a different ID -> ignored; v_shift and the sequence reflect the original ID.
